lc_tx_en_filter: RTL and testbench



---
 rtl/lc_tx_en_filter.sv | 132 +++++++++++++
 tb/tb_lc_tx_en_filter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc_tx_en_filter.sv
// Life-cycle enable consumer: synchronizes a raw lc_tx_e code, enables only after a stable
// run of On samples, and disables immediately on anything else. Invalid codes are flagged.
module lc_tx_en_filter #(
  parameter int NumStages    = 2,
  parameter int StableCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] lc_en_i,
  input  logic       err_clr_i,
  output logic [3:0] lc_en_o,
  output logic       en_o,
  output logic       invalid_o,
  output logic       err_sticky_o,
  output logic       arming_o
);

  localparam logic [3:0] LcOn  = 4'hA;
  localparam logic [3:0] LcOff = 4'h5;
  localparam int CntW = (StableCycles < 1) ? 1 : $clog2(StableCycles + 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(StableCycles);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {
    StOff,
    StArming,
    StOn
  } state_e;

  // All bits move together; only whole-code classification is meaningful downstream.
  logic [3:0] sync_q [NumStages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumStages; i++) begin
        sync_q[i] <= LcOff;
      end
    end else begin
      sync_q[0] <= lc_en_i;
      for (int i = 1; i < NumStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic [3:0] sample;
  logic       sample_on;
  logic       sample_inv;

  assign sample     = sync_q[NumStages-1];
  assign sample_on  = (sample == LcOn);
  assign sample_inv = (sample != LcOn) && (sample != LcOff);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = (cnt_q == CntTarget) ? cnt_q : cnt_q + CntOne;

  // The On transition fires on the edge whose sample completes the stable run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        if (sample_on) begin
          cnt_d   = CntOne;
          state_d = (CntOne == CntTarget) ? StOn : StArming;
        end
      end
      StArming: begin
        if (sample_on) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntTarget) begin
            state_d = StOn;
          end
        end else begin
          state_d = StOff;
          cnt_d   = '0;
        end
      end
      StOn: begin
        if (!sample_on) begin
          state_d = StOff;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  logic inv_prev_q;
  logic invalid_q;
  logic err_q;

  // Setting beats clearing so an error arriving together with a clear is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inv_prev_q <= 1'b0;
      invalid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inv_prev_q <= sample_inv;
      invalid_q  <= sample_inv && !inv_prev_q;
      if (sample_inv) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign lc_en_o      = (state_q == StOn) ? LcOn : LcOff;
  assign en_o         = (state_q == StOn);
  assign arming_o     = (state_q == StArming);
  assign invalid_o    = invalid_q;
  assign err_sticky_o = err_q;

endmodule

// File: tb/tb_lc_tx_en_filter.sv
// Bench for lc_tx_en_filter: three parameterisations driven in parallel and compared
// against a delay-line plus stable-run-length model of the enable filter.
module tb_lc_tx_en_filter;

  localparam logic [3:0] LcOn  = 4'hA;
  localparam logic [3:0] LcOff = 4'h5;

  int nst [3] = '{2, 2, 3};
  int sst [3] = '{4, 1, 4};

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] lc_en_i;
  logic       err_clr_i;

  logic [3:0] lc_w  [3];
  logic       en_w  [3];
  logic       inv_w [3];
  logic       err_w [3];
  logic       arm_w [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk_i = ~clk_i;

  lc_tx_en_filter #(.NumStages(2), .StableCycles(4)) u0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .lc_en_i(lc_en_i), .err_clr_i(err_clr_i),
    .lc_en_o(lc_w[0]), .en_o(en_w[0]), .invalid_o(inv_w[0]),
    .err_sticky_o(err_w[0]), .arming_o(arm_w[0]));

  lc_tx_en_filter #(.NumStages(2), .StableCycles(1)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .lc_en_i(lc_en_i), .err_clr_i(err_clr_i),
    .lc_en_o(lc_w[1]), .en_o(en_w[1]), .invalid_o(inv_w[1]),
    .err_sticky_o(err_w[1]), .arming_o(arm_w[1]));

  lc_tx_en_filter #(.NumStages(3), .StableCycles(4)) u2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .lc_en_i(lc_en_i), .err_clr_i(err_clr_i),
    .lc_en_o(lc_w[2]), .en_o(en_w[2]), .invalid_o(inv_w[2]),
    .err_sticky_o(err_w[2]), .arming_o(arm_w[2]));

  // Model: hist[i][0] is the newest raw input; the filter sees hist[i][N-1] at each edge.
  logic [3:0] hist [3][8];
  int         run  [3];
  logic       prev_inv [3];
  logic       m_inv [3];
  logic       m_err [3];

  int at     [3];
  int pulses [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) hist[i][j] = LcOff;
      run[i]      = 0;
      prev_inv[i] = 1'b0;
      m_inv[i]    = 1'b0;
      m_err[i]    = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [3:0] samp;
    logic       is_inv;
    for (int i = 0; i < 3; i++) begin
      samp = hist[i][nst[i]-1];
      for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = lc_en_i;
      is_inv = (samp != LcOn) && (samp != LcOff);
      m_inv[i]    = is_inv && !prev_inv[i];
      prev_inv[i] = is_inv;
      if (is_inv) m_err[i] = 1'b1;
      else if (err_clr_i) m_err[i] = 1'b0;
      if (samp == LcOn) run[i] = (run[i] < sst[i]) ? run[i] + 1 : run[i];
      else run[i] = 0;
    end
  endtask

  task automatic cmp(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[u%0d] cyc=%0d got=%0h expected=%0h", tag, i, cyc, got, exp);
    end
  endtask

  task automatic check_output();
    logic en_exp;
    for (int i = 0; i < 3; i++) begin
      en_exp = (run[i] >= sst[i]);
      cmp("lc_en", i, 32'(lc_w[i]), en_exp ? 32'hA : 32'h5);
      cmp("en", i, 32'(en_w[i]), 32'(en_exp));
      cmp("arming", i, 32'(arm_w[i]), 32'((run[i] > 0) && !en_exp));
      cmp("invalid", i, 32'(inv_w[i]), 32'(m_inv[i]));
      cmp("err_sticky", i, 32'(err_w[i]), 32'(m_err[i]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    cyc++;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input int n);
    lc_en_i = v;
    repeat (n) tick();
  endtask

  // Records, per instance, the first cycle en_o makes a transition to 'level'.
  task automatic run_measure(input logic [3:0] v, input int n, input logic level);
    logic prev [3];
    cyc = 0;
    lc_en_i = v;
    for (int i = 0; i < 3; i++) begin
      prev[i]   = en_w[i];
      at[i]     = -1;
      pulses[i] = 0;
    end
    repeat (n) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (at[i] < 0 && en_w[i] == level && prev[i] != level) at[i] = cyc;
        prev[i] = en_w[i];
        if (inv_w[i]) pulses[i]++;
      end
    end
  endtask

  task automatic hold_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_output();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_output();
  endtask

  initial begin
    int hold;
    int r;
    rst_ni    = 1'b1;
    lc_en_i   = LcOff;
    err_clr_i = 1'b0;
    #2;
    hold_reset();

    // Enable latency from a clean Off state.
    run_measure(LcOn, 10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cmp("en_rise_latency", i, 32'(at[i]), 32'(nst[i] + sst[i]));
      cmp("no_invalid_on_enable", i, 32'(pulses[i]), 32'd0);
    end

    // Disable path is immediate after synchronization.
    run_measure(LcOff, 6, 1'b0);
    for (int i = 0; i < 3; i++) cmp("en_fall_latency", i, 32'(at[i]), 32'(nst[i] + 1));

    // One-cycle glitch while arming restarts the count.
    apply_stimulus(LcOn, 2);
    apply_stimulus(LcOff, 1);
    run_measure(LcOn, 12, 1'b1);
    for (int i = 0; i < 3; i++) cmp("glitch_rise_latency", i, 32'(at[i]), 32'(nst[i] + sst[i]));

    // Invalid code from On: one pulse, immediate drop, sticky error, full re-enable.
    run_measure(4'hF, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cmp("inv_fall_latency", i, 32'(at[i]), 32'(nst[i] + 1));
      cmp("inv_pulse_count", i, 32'(pulses[i]), 32'd1);
    end
    run_measure(LcOn, 12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cmp("inv_rerise_latency", i, 32'(at[i]), 32'(nst[i] + sst[i]));
      cmp("inv_no_extra_pulse", i, 32'(pulses[i]), 32'd0);
      cmp("err_held", i, 32'(err_w[i]), 32'd1);
    end

    // Clear the error, then collide a clear with a fresh invalid entry.
    err_clr_i = 1'b1;
    apply_stimulus(LcOn, 1);
    err_clr_i = 1'b0;
    apply_stimulus(LcOn, 1);
    for (int i = 0; i < 3; i++) cmp("err_cleared", i, 32'(err_w[i]), 32'd0);
    apply_stimulus(4'hF, 2);
    err_clr_i = 1'b1;
    apply_stimulus(4'hF, 2);
    err_clr_i = 1'b0;
    apply_stimulus(LcOn, 8);
    for (int i = 0; i < 3; i++) cmp("set_beats_clear", i, 32'(err_w[i]), 32'd1);
    err_clr_i = 1'b1;
    apply_stimulus(LcOn, 1);
    err_clr_i = 1'b0;
    for (int i = 0; i < 3; i++) cmp("err_clear_valid", i, 32'(err_w[i]), 32'd0);

    // Reset in the middle of arming, then a full restart.
    apply_stimulus(LcOff, 6);
    apply_stimulus(LcOn, 5);
    cmp("arming_before_reset", 0, 32'(arm_w[0]), 32'd1);
    hold_reset();
    run_measure(LcOn, 10, 1'b1);
    for (int i = 0; i < 3; i++) cmp("restart_latency", i, 32'(at[i]), 32'(nst[i] + sst[i]));

    // Random phase: mostly On with Off and arbitrary codes mixed in.
    repeat (120) begin
      r = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 8));
      if (r < 6) lc_en_i = LcOn;
      else if (r < 8) lc_en_i = LcOff;
      else lc_en_i = 4'($urandom_range(0, 15));
      repeat (hold) begin
        err_clr_i = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    err_clr_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
